// File: rtl/adapter_pkg.sv
// Shared constants and helpers for the CPRI <-> AXIS IQ adapters (downlink and uplink).
// The sample layout matches the CPRI frame bus: sample k at bits [16k+15:16k].
package adapter_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned NSAMP    = 8;
  localparam int unsigned FRAME_W  = SAMPLE_W * NSAMP;
  localparam int unsigned AXIS_W   = 2 * SAMPLE_W;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } ser_state_e;

  // AXIS beat for sample idx: Q in the upper half, I in the lower half.
  function automatic logic [AXIS_W-1:0] pick_sample(input logic [FRAME_W-1:0] frame_i,
                                                    input logic [FRAME_W-1:0] frame_q,
                                                    input logic [IDX_W-1:0]   idx);
    return {frame_q[int'(idx)*SAMPLE_W +: SAMPLE_W], frame_i[int'(idx)*SAMPLE_W +: SAMPLE_W]};
  endfunction

endpackage

// File: rtl/iq_frame_buf2.sv
// Two-entry ping-pong frame store. The rd_nxt_* outputs show the head frame as it will be
// after this cycle's write/release, so the caller can register its output beat directly.
module iq_frame_buf2
  import adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [FRAME_W-1:0] wr_i_i,
  input  logic [FRAME_W-1:0] wr_q_i,
  input  logic               rel_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [1:0]         occ_o,
  output logic [FRAME_W-1:0] rd_nxt_i_o,
  output logic [FRAME_W-1:0] rd_nxt_q_o
);

  logic [FRAME_W-1:0] mem_i_q [2];
  logic [FRAME_W-1:0] mem_q_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               wr_ok;

  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
  assign occ_o   = occ_q;

  // A write into a full buffer is only legal when the head slot frees up in the same cycle.
  assign wr_ok = wr_en_i && (!full_o || rel_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ wr_ok;
    rd_ptr_d = rd_ptr_q ^ rel_i;
    occ_d    = occ_q + {1'b0, wr_ok} - {1'b0, rel_i};
    if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
      rd_nxt_i_o = wr_i_i;
      rd_nxt_q_o = wr_q_i;
    end else begin
      rd_nxt_i_o = mem_i_q[rd_ptr_d];
      rd_nxt_q_o = mem_q_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_i_q[wr_ptr_q] <= wr_i_i;
      mem_q_q[wr_ptr_q] <= wr_q_i;
    end
  end

endmodule

// File: rtl/adapter_dl.sv
// Downlink adapter: captures CPRI IQ frames into a two-frame buffer and serializes them as
// 8 AXIS beats per frame toward the DUC, counting frames dropped on overflow.
module adapter_dl
  import adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] iq_rx_i,
  input  logic [FRAME_W-1:0] iq_rx_q,
  input  logic               iq_rx_valid,
  output logic [AXIS_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               ovf_pulse,
  output logic [15:0]        drop_cnt
);

  ser_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [AXIS_W-1:0]  tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               handshake, release_frame, store, drop;
  logic               buf_full, buf_empty;
  logic [1:0]         buf_occ;
  logic [FRAME_W-1:0] nxt_i, nxt_q;

  iq_frame_buf2 u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (store),
    .wr_i_i     (iq_rx_i),
    .wr_q_i     (iq_rx_q),
    .rel_i      (release_frame),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .occ_o      (buf_occ),
    .rd_nxt_i_o (nxt_i),
    .rd_nxt_q_o (nxt_q)
  );

  assign m_axis_tvalid = (state_q == StStream);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign ovf_pulse     = ovf_q;
  assign drop_cnt      = cnt_q;

  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign release_frame = handshake && (idx_q == IDX_W'(NSAMP - 1));
  assign store         = iq_rx_valid && (!buf_full || release_frame);
  assign drop          = iq_rx_valid && !store;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!buf_empty || store) state_d = StStream;
      end
      StStream: begin
        if (release_frame && (buf_occ == 2'd1) && !store) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    idx_d = handshake ? idx_q + 3'd1 : idx_q;

    // Outputs are registered from next state so a fresh frame appears one cycle after capture.
    tdata_d = '0;
    tlast_d = 1'b0;
    if (state_d == StStream) begin
      tdata_d = pick_sample(nxt_i, nxt_q, idx_d);
      tlast_d = (idx_d == IDX_W'(NSAMP - 1));
    end

    ovf_d = drop;
    cnt_d = (drop && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_adapter_dl.sv
// Self-checking bench for adapter_dl: a queue-of-samples reference model predicts every
// output each cycle; per-scenario tasks add targeted checks on beats, drops and ordering.
module tb_adapter_dl;
  import adapter_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [FRAME_W-1:0] iq_rx_i, iq_rx_q;
  logic               iq_rx_valid;
  logic [AXIS_W-1:0]  m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic               ovf_pulse;
  logic [15:0]        drop_cnt;

  adapter_dl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iq_rx_i       (iq_rx_i),
    .iq_rx_q       (iq_rx_q),
    .iq_rx_valid   (iq_rx_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_pulse     (ovf_pulse),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: pending samples in emission order, plus overflow state.
  logic [31:0] sq[$];
  logic        m_ovf  = 1'b0;
  logic [15:0] m_drop = 16'd0;

  // Observations of the DUT for scenario-level checks.
  logic [31:0] got[$];
  int          beats, lasts, ovfs;
  logic [50:0] ev, obs;

  function automatic logic [50:0] exp_vec();
    int   s;
    logic v;
    logic [31:0] d;
    s = sq.size();
    v = (s > 0);
    d = 32'h0;
    if (v) d = sq[0];
    return {v, v && (s % 8 == 1), m_ovf, m_drop, d};
  endfunction

  function automatic void model_step();
    int s, occ;
    bit hs, rel, acc;
    if (!rst_n) begin
      sq.delete();
      m_ovf  = 1'b0;
      m_drop = 16'd0;
      return;
    end
    s   = sq.size();
    occ = (s + 7) / 8;
    hs  = (s > 0) && m_axis_tready;
    rel = hs && (s % 8 == 1);
    acc = iq_rx_valid && (occ < 2 || rel);
    m_ovf = iq_rx_valid && !acc;
    if (m_ovf && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (hs) void'(sq.pop_front());
    if (acc)
      for (int k = 0; k < 8; k++) sq.push_back({iq_rx_q[16*k +: 16], iq_rx_i[16*k +: 16]});
  endfunction

  // Advance one clock: model and DUT see the same inputs at the edge; returns at negedge.
  task automatic tick();
    logic pre;
    pre = m_axis_tvalid && m_axis_tready;
    if (pre) begin
      got.push_back(m_axis_tdata);
      if (m_axis_tlast) lasts++;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (pre) beats++;
    if (ovf_pulse) ovfs++;
  endtask

  task automatic rand_frame(output logic [FRAME_W-1:0] fi, output logic [FRAME_W-1:0] fq);
    for (int w = 0; w < 4; w++) begin
      fi[32*w +: 32] = $urandom();
      fq[32*w +: 32] = $urandom();
    end
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < 8; k++) begin
      iq_rx_i[16*k +: 16] = 16'(k);
      iq_rx_q[16*k +: 16] = 16'h0100 + 16'(k);
    end
  endtask

  task automatic clear_obs();
    got.delete();
    beats = 0;
    lasts = 0;
    ovfs  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    rand_frame(iq_rx_i, iq_rx_q);
    iq_rx_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== 51'h0) $display("FAIL reset_outputs cyc%0d got %h exp 0", c, obs);
      else n_pass++;
    end
    iq_rx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    ev = exp_vec();
    obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
    n_total++;
    if (obs !== ev) $display("FAIL reset_release got %h exp %h", obs, ev);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [31:0] e;
    clear_obs();
    ramp_frame();
    m_axis_tready = 1'b1;
    iq_rx_valid = 1'b1;
    tick();
    iq_rx_valid = 1'b0;
    n_total++;
    if (m_axis_tvalid !== 1'b1) $display("FAIL single_latency tvalid got %b exp 1", m_axis_tvalid);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL single_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
      tick();
    end
    n_total++;
    if (beats != 8 || lasts != 1) $display("FAIL single_beats got %0d/%0d exp 8/1", beats, lasts);
    else n_pass++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      e = {16'h0100 + 16'(k), 16'(k)};
      n_total++;
      if (got[k] !== e) $display("FAIL single_data k%0d got %h exp %h", k, got[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    clear_obs();
    ramp_frame();
    m_axis_tready = 1'b0;
    iq_rx_valid = 1'b1;
    tick();
    iq_rx_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      m_axis_tready = (c % 2 == 0);
      tick();
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL stall_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
    end
    n_total++;
    if (beats != 8 || m_axis_tvalid !== 1'b0)
      $display("FAIL stall_beats got %0d tvalid %b exp 8 tvalid 0", beats, m_axis_tvalid);
    else n_pass++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      e = {16'h0100 + 16'(k), 16'(k)};
      n_total++;
      if (got[k] !== e) $display("FAIL stall_order k%0d got %h exp %h", k, got[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [FRAME_W-1:0] fi[3], fq[3];
    logic [31:0] e;
    clear_obs();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fi[f], fq[f]);
      iq_rx_i = fi[f];
      iq_rx_q = fq[f];
      iq_rx_valid = 1'b1;
      tick();
    end
    iq_rx_valid = 1'b0;
    tick();
    n_total++;
    if (ovfs != 1 || drop_cnt !== 16'd1)
      $display("FAIL ovf_drop got ovf %0d cnt %0d exp ovf 1 cnt 1", ovfs, drop_cnt);
    else n_pass++;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL ovf_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
      tick();
    end
    n_total++;
    if (beats != 16 || lasts != 2) $display("FAIL ovf_beats got %0d/%0d exp 16/2", beats, lasts);
    else n_pass++;
    for (int b = 0; b < 16 && b < got.size(); b++) begin
      e = {fq[b/8][16*(b%8) +: 16], fi[b/8][16*(b%8) +: 16]};
      n_total++;
      if (got[b] !== e) $display("FAIL ovf_data beat%0d got %h exp %h", b, got[b], e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit sent;
    clear_obs();
    sent = 1'b0;
    m_axis_tready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      rand_frame(iq_rx_i, iq_rx_q);
      iq_rx_valid = 1'b1;
      tick();
    end
    iq_rx_valid = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      // Strike exactly on the sample-7 handshake of the head frame while full.
      if (!sent && sq.size() == 9) begin
        rand_frame(iq_rx_i, iq_rx_q);
        iq_rx_valid = 1'b1;
        sent = 1'b1;
      end else iq_rx_valid = 1'b0;
      tick();
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL b2b_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
    end
    iq_rx_valid = 1'b0;
    n_total++;
    if (beats != 24 || ovfs != 0 || drop_cnt !== 16'd1)
      $display("FAIL b2b_stream got beats %0d ovf %0d cnt %0d exp 24 0 1", beats, ovfs, drop_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL b2b_idle tvalid got %b exp 0", m_axis_tvalid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    clear_obs();
    m_axis_tready = 1'b1;
    rand_frame(iq_rx_i, iq_rx_q);
    iq_rx_valid = 1'b1;
    tick();
    iq_rx_valid = 1'b0;
    for (int c = 0; c < 8 && beats < 4; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if (m_axis_tvalid !== 1'b0 || drop_cnt !== 16'd0)
      $display("FAIL rstmid_clear got tvalid %b cnt %0d exp 0 0", m_axis_tvalid, drop_cnt);
    else n_pass++;
    tick();
    rand_frame(iq_rx_i, iq_rx_q);
    e = {iq_rx_q[15:0], iq_rx_i[15:0]};
    iq_rx_valid = 1'b1;
    tick();
    iq_rx_valid = 1'b0;
    n_total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e)
      $display("FAIL rstmid_restart got %b %h exp 1 %h", m_axis_tvalid, m_axis_tdata, e);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL rstmid_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_frame(iq_rx_i, iq_rx_q);
      iq_rx_valid = ($urandom_range(0, 3) == 0);
      m_axis_tready = ($urandom_range(0, 2) != 0);
      tick();
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL random_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
    end
    iq_rx_valid = 1'b0;
  endtask

  task automatic test_saturate();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_axis_tready = 1'b0;
    iq_rx_valid = 1'b1;
    // Two fills, then 65534 drops brings the counter to FFFE.
    for (int c = 0; c < 65536; c++) begin
      tick();
      ev = exp_vec();
      obs = {m_axis_tvalid, m_axis_tlast, ovf_pulse, drop_cnt, m_axis_tdata};
      n_total++;
      if (obs !== ev) $display("FAIL sat_cycle cyc%0d got %h exp %h", c, obs, ev);
      else n_pass++;
    end
    n_total++;
    if (drop_cnt !== 16'hFFFE) $display("FAIL sat_pre got %h exp fffe", drop_cnt);
    else n_pass++;
    ovfs = 0;
    for (int c = 0; c < 3; c++) tick();
    iq_rx_valid = 1'b0;
    tick();
    n_total++;
    if (drop_cnt !== 16'hFFFF || ovfs != 3)
      $display("FAIL sat_hold got cnt %h ovf %0d exp ffff 3", drop_cnt, ovfs);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    iq_rx_valid = 1'b0;
    m_axis_tready = 1'b0;
    iq_rx_i = '0;
    iq_rx_q = '0;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adapter_dl.md
ADAPTER_DL -- requirements
Module: adapter_dl

Interface
REQ-001 Parameters: none; sample width 16, samples per frame 8, fixed.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 iq_rx_i  input  128  I part of one CPRI frame, sample k at bits [16k+15:16k].
REQ-005 iq_rx_q  input  128  Q part of one CPRI frame, same bit layout as iq_rx_i.
REQ-006 iq_rx_valid  input  1  one-cycle strobe; iq_rx_i/iq_rx_q hold a new frame.
REQ-007 m_axis_tdata  output  32  sample to DUC: [15:0]=I, [31:16]=Q.
REQ-008 m_axis_tvalid  output  1  AXIS valid.
REQ-009 m_axis_tready  input  1  AXIS ready from DUC.
REQ-010 m_axis_tlast  output  1  high with sample 7 of each frame.
REQ-011 ovf_pulse  output  1  one-cycle pulse when an incoming frame is dropped.
REQ-012 drop_cnt  output  16  count of dropped frames, saturating at 16'hFFFF.

Function
REQ-013 Sample k SHALL be {iq_rx_q[16k+15:16k], iq_rx_i[16k+15:16k]}; emit k=0 first, k=7 last.
REQ-014 A two-entry frame buffer (ping-pong, write/read pointer, occupancy 0..2) SHALL hold captured frames.
REQ-015 On iq_rx_valid with occupancy<2, the frame SHALL be stored in the write slot that cycle.
REQ-016 On iq_rx_valid with occupancy==2 and a frame release (sample-7 handshake) in the same cycle, the frame SHALL be stored; no overflow.
REQ-017 On iq_rx_valid with occupancy==2 and no release that cycle, the frame SHALL be dropped, buffer contents unchanged, ovf_pulse high next cycle, drop_cnt incremented (saturating).
REQ-018 Serializer states: IDLE (tvalid=0) and STREAM (tvalid=1), plus 3-bit sample index.
REQ-019 IDLE->STREAM when occupancy>0; tvalid SHALL rise the cycle after a frame is stored into an empty buffer (latency 1), with index 0.
REQ-020 In STREAM, tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-021 On handshake (tvalid&tready) index SHALL increment; on index 7 handshake the frame is released and index wraps to 0.
REQ-022 After release: occupancy>0 remaining -> stay in STREAM, next frame's sample 0 presented next cycle, no bubble; else -> IDLE, tvalid=0 next cycle.
REQ-023 tready high continuously SHALL yield one sample per cycle; a frame every 8 cycles SHALL never overflow.
REQ-024 tvalid SHALL NOT depend combinationally on tready; all outputs registered.

Reset
REQ-025 While rst_n=0: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, ovf_pulse=0, drop_cnt=0, occupancy=0, pointers=0, index=0, state IDLE.
REQ-026 Reset mid-frame SHALL discard all buffered frames; tvalid low the cycle after rst_n sampled low; iq_rx_valid ignored during reset.
REQ-027 First frame accepted is the first iq_rx_valid sampled with rst_n=1.

Structure
REQ-028 Shared package adapter_pkg SHALL hold SAMPLE_W=16, NSAMP=8, FRAME_W=128, AXIS_W=32, shared with the uplink adapter.
REQ-029 Two-entry frame storage SHALL be sub-module iq_frame_buf2 (write, read, release, full/empty); serializer FSM and counters in adapter_dl.

Verification
REQ-030 Single frame, I=16'h0000..0007, Q=16'h0100..0107, tready=1 -> tvalid one cycle after strobe, tdata 32'h0100_0000..32'h0107_0007 on 8 consecutive cycles, tlast on 8th only.
REQ-031 Same frame, tready toggling 1/0 each cycle -> 8 beats over 16 cycles, data stable during stalls, order unchanged.
REQ-032 tready=0, three strobes -> first two stored, third dropped: ovf_pulse once, drop_cnt=1; then tready=1 -> 16 beats, frames 1 and 2 only.
REQ-033 occupancy=2, strobe coincident with sample-7 handshake -> no ovf_pulse, 24 total beats, no bubble between frames.
REQ-034 rst_n low at beat 4 for 1 cycle -> tvalid 0 next cycle, drop_cnt=0, next strobe restarts at sample 0.
REQ-035 Force drop_cnt to 16'hFFFE, cause 3 drops -> drop_cnt holds 16'hFFFF, ovf_pulse fires 3 times.
